// File: rtl/twos_neg_scheduler_if.sv
// Purpose : operand request (two requesters) and tagged result bus of the serial negator.
// Latency : n/a (signal bundle only).
// Backpressure: valid/ready on both request ports and on the result port.
//   master : requester/consumer side (drives operands and res_ready)
//   slave  : negation engine side (drives readies and the result)
interface twos_neg_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_ovf;
    logic             res_ready;

    modport master (
        output req0_valid, req0_data,
        input  req0_ready,
        output req1_valid, req1_data,
        input  req1_ready,
        input  res_valid, res_data, res_id, res_ovf,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_data,
        output req0_ready,
        input  req1_valid, req1_data,
        output req1_ready,
        output res_valid, res_data, res_id, res_ovf,
        input  res_ready
    );
endinterface

// File: rtl/twos_neg_scheduler.sv
// Purpose : bit-serial two's-complement negator shared round-robin by two requesters.
// Latency : grant edge T -> res_valid from T+WIDTH; minimum issue interval WIDTH+2 cycles.
// Backpressure: result held in DONE until res_ready; request readies low outside IDLE.
//   Ports: clk, rst_n (synchronous, active-low), bus (slave modport): req0/req1
//   operand ports, res_* tagged result port with overflow flag.
module twos_neg_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    twos_neg_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] shreg;
    // Only WIDTH-1 result bits need storing: the last sum bit goes straight to res_data.
    logic [WIDTH-2:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;

    logic [WIDTH-1:0] res_data_q;
    logic             res_valid_q;
    logic             res_id_q;
    logic             res_ovf_q;

    logic             ready0;
    logic             ready1;
    logic             gnt_id;
    logic             take;
    logic             shift_last;
    logic             sum_bit;
    logic [WIDTH-1:0] acc_full;
    logic [WIDTH-1:0] gnt_data;

    // Tie-break favours the requester that was not served last.
    assign gnt_id     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    assign gnt_data   = gnt_id ? bus.req1_data : bus.req0_data;
    assign take       = ready0 | ready1;
    assign shift_last = (cnt == CNT_W'(WIDTH - 1));
    // One full-adder slice: ~A[i] + carry, sum only.
    assign sum_bit    = ~shreg[0] ^ carry;
    assign acc_full   = {sum_bit, acc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    ready0    = ~gnt_id;
                    ready1    = gnt_id;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg       <= '0;
            acc         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            last_grant  <= 1'b1;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        shreg      <= gnt_data;
                        carry      <= 1'b1;
                        cnt        <= '0;
                        res_id_q   <= gnt_id;
                        last_grant <= gnt_id;
                        res_ovf_q  <= (gnt_data == {1'b1, {(WIDTH-1){1'b0}}});
                    end
                end
                SHIFT: begin
                    carry <= ~shreg[0] & carry;
                    acc   <= acc_full[WIDTH-1:1];
                    shreg <= shreg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    // Final carry-out is dropped: result is mod 2^WIDTH.
                    if (shift_last) begin
                        res_data_q  <= acc_full;
                        res_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.res_ovf    = res_ovf_q;
endmodule

// File: tb/tb_twos_neg_scheduler.sv
// Purpose : self-checking bench for twos_neg_scheduler (WIDTH=8).
// Latency : expects res_valid exactly WIDTH edges after the grant edge.
// Backpressure: exercises result stall, reset abandon and round-robin alternation.
module tb_twos_neg_scheduler;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    twos_neg_scheduler_if #(.WIDTH(WIDTH)) bus ();

    twos_neg_scheduler #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] e;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b0;
        #1;
        chk("ready during reset", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
        tick();
        tick();
        chk("reset res_valid", {31'd0, bus.res_valid}, 0);
        chk("reset res_data", {24'd0, bus.res_data}, 0);
        chk("reset res_id", {31'd0, bus.res_id}, 0);
        chk("reset res_ovf", {31'd0, bus.res_ovf}, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n          = 1'b1;
    endtask

    // Single request; operand data is scrambled right after the grant edge.
    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] e,
                          input logic eovf, input string nm);
        int lat;
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = a;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = a;
        end
        #1;
        chk({nm, " ready"}, {31'd0, id ? bus.req1_ready : bus.req0_ready}, 1);
        chk({nm, " other ready"}, {31'd0, id ? bus.req0_ready : bus.req1_ready}, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = ~a;
        bus.req1_data  = ~a;
        #1;
        chk({nm, " ready in shift"}, {30'd0, bus.req1_ready, bus.req0_ready}, 0);
        wait_result(lat);
        chk({nm, " latency"}, lat, WIDTH);
        chk({nm, " data"}, {24'd0, bus.res_data}, {24'd0, e});
        chk({nm, " id"}, {31'd0, bus.res_id}, {31'd0, id});
        chk({nm, " ovf"}, {31'd0, bus.res_ovf}, {31'd0, eovf});
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({nm, " valid drop"}, {31'd0, bus.res_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   w;
        int   gcyc;
        int   prev;
        logic expid;

        bus.req0_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.res_ready  = 1'b0;

        vecs[0] = '{1'b0, 8'h05, 8'hFB, 1'b0};
        vecs[1] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 8'h80, 8'h80, 1'b1};
        vecs[3] = '{1'b1, 8'hFF, 8'h01, 1'b0};
        vecs[4] = '{1'b1, 8'h7F, 8'h81, 1'b0};
        vecs[5] = '{1'b0, 8'h01, 8'hFF, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b1};
        vecs[7] = '{1'b0, 8'h5A, 8'hA6, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].e, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        // Both requesters valid from reset: req0 first, then strict alternation.
        do_reset();
        bus.req0_data  = 8'h01;
        bus.req1_data  = 8'h02;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        prev = 0;
        #1;
        for (int k = 0; k < 8; k++) begin
            expid = k[0];
            w = 0;
            while (!(bus.req0_ready || bus.req1_ready) && w < 40) begin
                tick();
                w++;
            end
            chk($sformatf("rr%0d grant", k), {30'd0, bus.req1_ready, bus.req0_ready},
                expid ? 32'd2 : 32'd1);
            gcyc = cyc;
            if (k > 0) chk($sformatf("rr%0d interval", k), gcyc - prev, WIDTH + 2);
            prev = gcyc;
            tick();
            wait_result(lat);
            chk($sformatf("rr%0d latency", k), lat, WIDTH);
            chk($sformatf("rr%0d data", k), {24'd0, bus.res_data}, expid ? 32'hFE : 32'hFF);
            chk($sformatf("rr%0d id", k), {31'd0, bus.res_id}, {31'd0, expid});
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        bus.res_ready = 1'b0;

        // Backpressure in DONE with both requesters waiting.
        bus.req0_data  = 8'h33;
        bus.req0_valid = 1'b1;
        #1;
        tick();
        bus.req0_valid = 1'b0;
        wait_result(lat);
        chk("bp data", {24'd0, bus.res_data}, 32'hCD);
        bus.req0_data  = 8'h44;
        bus.req1_data  = 8'h55;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d valid", i), {31'd0, bus.res_valid}, 1);
            chk($sformatf("bp%0d data", i), {24'd0, bus.res_data}, 32'hCD);
            chk($sformatf("bp%0d id/ovf", i), {30'd0, bus.res_id, bus.res_ovf}, 0);
            chk($sformatf("bp%0d readies", i), {30'd0, bus.req1_ready, bus.req0_ready}, 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("bp release valid", {31'd0, bus.res_valid}, 0);
        chk("bp idle grant", {30'd0, bus.req1_ready, bus.req0_ready}, 2);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // Reset during the 4th SHIFT cycle abandons the operation.
        bus.req0_data  = 8'h22;
        bus.req0_valid = 1'b1;
        #1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("mid reset readies", {30'd0, bus.req1_ready, bus.req0_ready}, 0);
        tick();
        chk("mid reset outputs",
            {22'd0, bus.res_valid, bus.res_data, bus.res_id}, 0);
        chk("mid reset ovf", {31'd0, bus.res_ovf}, 0);
        bus.req0_data = 8'h10;
        bus.req1_data = 8'h55;
        rst_n         = 1'b1;
        #1;
        chk("post reset tie grant", {30'd0, bus.req1_ready, bus.req0_ready}, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = 8'hAA;
        wait_result(lat);
        chk("post reset latency", lat, WIDTH);
        chk("post reset data", {24'd0, bus.res_data}, 32'hF0);
        chk("post reset id", {31'd0, bus.res_id}, 0);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;

        // Operand changed in flight must not leak into the result.
        run_op(1'b0, 8'h05, 8'hFB, 1'b0, "inflight");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
